// File: rtl/port_io_ctrl_if.sv
// CPU port bus: address/data/strobes out from the CPU, registered read data back.
interface port_io_ctrl_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] portaddr;
    logic [WORD_SIZE-1:0] portval;
    logic                 portget;
    logic                 portset;
    logic [WORD_SIZE-1:0] portout;

    modport master (output portaddr, portval, portget, portset, input portout);
    modport slave  (input portaddr, portval, portget, portset, output portout);
endinterface

// File: rtl/port_io_ctrl.sv
// I/O-port peripheral: LED register, FIFO-buffered 8N1 transmitter, status
// register and free-running cycle counter behind the CPU port bus.
module port_io_ctrl #(
    parameter int WORD_SIZE    = 16,
    parameter int TX_DEPTH     = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    port_io_ctrl_if.slave        bus,
    output logic [WORD_SIZE-1:0] leds,
    output logic                 tx
);
    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [WORD_SIZE-1:0] A_LED    = WORD_SIZE'(0);
    localparam logic [WORD_SIZE-1:0] A_TXDATA = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] A_STATUS = WORD_SIZE'(2);
    localparam logic [WORD_SIZE-1:0] A_COUNT  = WORD_SIZE'(3);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    tx_state_t            state;
    logic [7:0]           mem [TX_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          occ;
    logic                 overflow;
    logic [15:0]          count;
    logic [7:0]           shreg;
    logic [TW-1:0]        timer;
    logic [2:0]           bit_idx;
    logic [WORD_SIZE-1:0] rdata;

    logic empty, full, busy, push_req, push, pop, rd_status, clr_count, bit_end;
    logic [3:0] status;

    assign empty     = (occ == '0);
    assign full      = (occ == (PW+1)'(TX_DEPTH));
    assign busy      = (state != IDLE);
    assign push_req  = bus.portset && (bus.portaddr == A_TXDATA);
    // Full is judged before the pop of this cycle, so a push at full is lost.
    assign push      = push_req && !full;
    assign pop       = (state == IDLE) && !empty;
    assign rd_status = bus.portget && (bus.portaddr == A_STATUS);
    assign clr_count = bus.portset && (bus.portaddr == A_COUNT);
    assign bit_end   = (timer == TW'(CLKS_PER_BIT - 1));
    assign status    = {overflow, busy, empty, full};

    always_comb begin
        rdata = '0;
        case (bus.portaddr)
            A_LED:    rdata = leds;
            A_STATUS: rdata = {{(WORD_SIZE-4){1'b0}}, status};
            A_COUNT:  rdata = WORD_SIZE'(count);
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.portval[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.portout <= '0;
            leds        <= '0;
            overflow    <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
        end else begin
            if (bus.portget) bus.portout <= rdata;
            if (bus.portset && (bus.portaddr == A_LED)) leds <= bus.portval;
            // A new overflow on the same edge as a STATUS read stays visible.
            if (rd_status) overflow <= 1'b0;
            if (push_req && full) overflow <= 1'b1;
            count <= clr_count ? 16'd0 : count + 16'd1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (PW+1)'(1);
                2'b01:   occ <= occ - (PW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx    <= 1'b1;
                    timer <= '0;
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else timer <= timer + TW'(1);
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else timer <= timer + TW'(1);
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        state <= IDLE;
                    end else timer <= timer + TW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_port_io_ctrl.sv
// Directed bench for port_io_ctrl: LED, TX frames, FIFO overflow, counter, reset.
module tb_port_io_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] leds;
    logic        tx;
    int          errors = 0;
    int          checks = 0;

    port_io_ctrl_if #(.WORD_SIZE(16)) bus ();

    port_io_ctrl #(.WORD_SIZE(16), .TX_DEPTH(4), .CLKS_PER_BIT(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .leds(leds), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        bus.portaddr = a; bus.portval = v; bus.portset = 1'b1;
        tick();
        bus.portset = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.portaddr = a; bus.portget = 1'b1;
        tick();
        bus.portget = 1'b0;
    endtask

    // Samples each bit mid-period after finding the start edge.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int n;
        n = 0; ok = 1'b1; b = '0;
        while (tx !== 1'b0 && n < 400) begin tick(); n++; end
        if (n >= 400) ok = 1'b0;
        else begin
            repeat (8) tick();
            if (tx !== 1'b0) ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat (16) tick();
                b[k] = tx;
            end
            repeat (16) tick();
            if (tx !== 1'b1) ok = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic       ok;
        logic [7:0] frame_byte;
        logic       exp_bit;
        int         bad;

        bus.portaddr = '0; bus.portval = '0; bus.portget = 1'b0; bus.portset = 1'b0;
        #12 reset_n = 1'b1;
        tick();

        // reset state
        chk("rst_portout", bus.portout, 16'h0000);
        chk("rst_leds", leds, 16'h0000);
        chk("rst_tx", {15'd0, tx}, 16'h0001);
        rd(16'h0002);
        chk("rst_status", bus.portout, 16'h0002);

        // LED write / read
        wr(16'h0000, 16'hA5C3);
        chk("led_write", leds, 16'hA5C3);
        rd(16'h0000);
        chk("led_read", bus.portout, 16'hA5C3);

        // unmapped read, ignored writes, full-width decode
        rd(16'h0010);
        chk("unmapped_read", bus.portout, 16'h0000);
        wr(16'h0002, 16'hFFFF);
        wr(16'h8000, 16'h1234);
        wr(16'h0100, 16'h5678);
        chk("ignored_wr_leds", leds, 16'hA5C3);
        rd(16'h0002);
        chk("ignored_wr_status", bus.portout, 16'h0002);

        // simultaneous read and write of LED: old value returned, new stored
        bus.portaddr = 16'h0000; bus.portval = 16'h1111;
        bus.portget = 1'b1; bus.portset = 1'b1;
        tick();
        bus.portget = 1'b0; bus.portset = 1'b0;
        chk("getset_portout", bus.portout, 16'hA5C3);
        chk("getset_leds", leds, 16'h1111);

        // single frame 0x55, cycle-exact
        wr(16'h0001, 16'h1255);
        chk("tx_idle_after_push", {15'd0, tx}, 16'h0001);
        tick();
        frame_byte = 8'h55;
        bad = 0;
        bus.portaddr = 16'h0002;
        for (int i = 0; i < 160; i++) begin
            if (i / 16 == 0)      exp_bit = 1'b0;
            else if (i / 16 == 9) exp_bit = 1'b1;
            else                  exp_bit = frame_byte[i/16 - 1];
            if (tx !== exp_bit) bad++;
            if (i == 41) begin
                bus.portget = 1'b0;
                chk("status_mid_frame", bus.portout, 16'h0006);
            end
            if (i == 40) bus.portget = 1'b1;
            tick();
        end
        chk("frame_55_bad_cycles", 16'(bad), 16'h0000);
        rd(16'h0002);
        chk("status_after_frame", bus.portout, 16'h0002);

        // overflow: prime a frame, then five back-to-back pushes
        wr(16'h0001, 16'h00FF);
        repeat (20) tick();
        for (int i = 1; i <= 5; i++) wr(16'h0001, 16'(i));
        rd(16'h0002);
        chk("status_overflow", bus.portout, 16'h000D);
        rd(16'h0002);
        chk("status_reread", bus.portout, 16'h0005);
        for (int i = 1; i <= 4; i++) begin
            rx_byte(rb, ok);
            chk("rx_ok", {15'd0, ok}, 16'h0001);
            chk("rx_byte", {8'd0, rb}, 16'(i));
        end
        repeat (16) tick();
        rd(16'h0002);
        chk("status_drained", bus.portout, 16'h0002);

        // counter: clear, then exact count and wrap
        wr(16'h0003, 16'hBEEF);
        repeat (9) tick();
        rd(16'h0003);
        chk("count_9", bus.portout, 16'h0009);
        wr(16'h0003, 16'h0000);
        repeat (65535) tick();
        rd(16'h0003);
        chk("count_ffff", bus.portout, 16'hFFFF);
        rd(16'h0003);
        chk("count_wrap", bus.portout, 16'h0000);

        // reset in the middle of a data bit
        wr(16'h0001, 16'h0000);
        wr(16'h0001, 16'h00AA);
        repeat (40) tick();
        chk("tx_mid_data", {15'd0, tx}, 16'h0000);
        reset_n = 1'b0;
        #2;
        chk("async_rst_tx", {15'd0, tx}, 16'h0001);
        chk("async_rst_leds", leds, 16'h0000);
        chk("async_rst_portout", bus.portout, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        rd(16'h0002);
        chk("status_after_rst", bus.portout, 16'h0002);
        repeat (20) tick();
        chk("tx_idle_after_rst", {15'd0, tx}, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
